// File: rtl/sid_write_router_pkg.sv
`default_nettype none
// ============================================================================
// sid_pkg : shared types and constants for the multi-SID write router
// Revision: 1.0
// ============================================================================
package sid_pkg;

  localparam int SID_REG_BITS  = 5;
  localparam int SID_CHIP_BITS = 3;

  typedef struct packed {
    logic [SID_CHIP_BITS-1:0] chip;
    logic [SID_REG_BITS-1:0]  regnum;
    logic [7:0]               data;
  } sid_wr_t;

  typedef enum logic {ADDR, DATA} parse_state_t;

  typedef enum logic {IDLE, STROBE} issue_state_t;

endpackage
`default_nettype wire

// File: rtl/sid_write_router_if.sv
`default_nettype none
// ============================================================================
// sid_write_router_if : byte-stream input and shared SID bus output
// Revision: 1.0
// ============================================================================
interface sid_write_router_if #(
  parameter int N_SID = 2
);
  import sid_pkg::*;

  logic [7:0]              s_tdata;
  logic                    s_tvalid;
  logic                    s_tready;
  logic [SID_REG_BITS-1:0] sid_addr;
  logic [7:0]              sid_data;
  logic [N_SID-1:0]        sid_n_cs;

  // master: stream source / bus observer; slave: the router
  modport master (
    output s_tdata, s_tvalid,
    input  s_tready, sid_addr, sid_data, sid_n_cs
  );

  modport slave (
    input  s_tdata, s_tvalid,
    output s_tready, sid_addr, sid_data, sid_n_cs
  );

endinterface
`default_nettype wire

// File: rtl/sid_write_router_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock FIFO with level output and registered head word
// Revision: 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  wire logic                       sysclk,
  input  wire logic                       n_reset,
  input  wire logic                       push_i,
  input  wire logic                       pop_i,
  input  wire logic [WIDTH-1:0]           din_i,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [$clog2(DEPTH+1)-1:0]      level_o,
  output logic [WIDTH-1:0]                head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q;
  logic [WIDTH-1:0] head_q;
  logic             w_push, w_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign rd_ptr_d = rd_ptr_q + AW'(w_pop);
  assign level_o = level_q;
  assign head_o  = head_q;

  always_ff @(posedge sysclk) begin
    if (w_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge sysclk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(w_push);
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_q + LW'(w_push) - LW'(w_pop);
      // the incoming word becomes the head when it lands where the read pointer is going
      if (w_push && (wr_ptr_q == rd_ptr_d)) head_q <= din_i;
      else                                  head_q <= mem_q[rd_ptr_d];
    end
  end

endmodule
`default_nettype wire

// File: rtl/sid_write_router.sv
`default_nettype none
// ============================================================================
// sid_write_router : parses (addr,data) byte pairs and issues paced writes
// to one of N_SID SID chips through a write FIFO.  Revision: 1.0
// ============================================================================
module sid_write_router
  import sid_pkg::*;
#(
  parameter int N_SID      = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 50000
) (
  input  wire logic                          sysclk,
  input  wire logic                          n_reset,
  input  wire logic                          clk_en_i,
  sid_write_router_if.slave                  bus,
  output logic                               overflow_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level_o
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  parse_state_t             pstate_q;
  issue_state_t             istate_q;
  logic [SID_CHIP_BITS-1:0] chip_q;
  logic [SID_REG_BITS-1:0]  reg_q;
  logic [TW-1:0]            tmo_q;
  logic                     overflow_q;
  logic [SID_REG_BITS-1:0]  addr_q;
  logic [7:0]               data_q;
  logic [N_SID-1:0]         n_cs_q;

  logic                     w_full, w_empty, w_tready, w_accept, w_chip_ok, w_push, w_pop;
  logic [SID_CHIP_BITS-1:0] w_chip;
  sid_wr_t                  w_din, w_head;

  assign w_chip    = bus.s_tdata[7:5];
  assign w_chip_ok = (32'(w_chip) < N_SID);
  assign w_tready  = !((pstate_q == DATA) && w_full);
  assign w_accept  = bus.s_tvalid && w_tready;
  assign w_push    = (pstate_q == DATA) && w_accept;
  assign w_pop     = (istate_q == IDLE) && clk_en_i && !w_empty;
  assign w_din     = '{chip: chip_q, regnum: reg_q, data: bus.s_tdata};

  sync_fifo #(
    .WIDTH ($bits(sid_wr_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sysclk  (sysclk),
    .n_reset (n_reset),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   (w_din),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (fifo_level_o),
    .head_o  (w_head)
  );

  // Parser: out-of-range chip bytes in ADDR are dropped, which resyncs the pair framing
  always_ff @(posedge sysclk or negedge n_reset) begin
    if (!n_reset) begin
      pstate_q   <= ADDR;
      chip_q     <= '0;
      reg_q      <= '0;
      tmo_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (bus.s_tvalid && !w_tready) overflow_q <= 1'b1;
      case (pstate_q)
        ADDR: begin
          if (w_accept && w_chip_ok) begin
            chip_q   <= w_chip;
            reg_q    <= bus.s_tdata[SID_REG_BITS-1:0];
            tmo_q    <= '0;
            pstate_q <= DATA;
          end
        end
        DATA: begin
          if (w_accept) begin
            tmo_q    <= '0;
            pstate_q <= ADDR;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            tmo_q    <= '0;
            pstate_q <= ADDR;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
      endcase
    end
  end

  // Issuer: select goes low on one clk_en and is released on the next
  always_ff @(posedge sysclk or negedge n_reset) begin
    if (!n_reset) begin
      istate_q <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      n_cs_q   <= '1;
    end else begin
      case (istate_q)
        IDLE: begin
          if (w_pop) begin
            addr_q   <= w_head.regnum;
            data_q   <= w_head.data;
            n_cs_q   <= ~(N_SID'(1) << w_head.chip);
            istate_q <= STROBE;
          end
        end
        STROBE: begin
          if (clk_en_i) begin
            n_cs_q   <= '1;
            istate_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.s_tready = w_tready;
  assign bus.sid_addr = addr_q;
  assign bus.sid_data = data_q;
  assign bus.sid_n_cs = n_cs_q;
  assign overflow_o   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sid_write_router.sv
`default_nettype none
// ============================================================================
// tb_sid_write_router : scoreboard bench; stimulus pushes expected writes,
// a bus monitor pops and compares them when a chip select falls.
// ============================================================================
module tb_sid_write_router;
  import sid_pkg::*;

  localparam int N_SID      = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 100;
  localparam int CE_PERIOD  = 50;

  logic       sysclk  = 1'b0;
  logic       n_reset = 1'b1;
  logic       clk_en  = 1'b0;
  logic       overflow;
  logic [2:0] fifo_level;
  bit         ce_on = 1'b0;
  int         ce_cnt = 0;
  int         n_tests = 0;
  int         n_fail  = 0;
  sid_wr_t    sb[$];

  logic [1:0] mon_prev = 2'b11;
  int         mon_low  = 0;

  sid_write_router_if #(.N_SID(N_SID)) bus ();

  sid_write_router #(
    .N_SID      (N_SID),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .sysclk       (sysclk),
    .n_reset      (n_reset),
    .clk_en_i     (clk_en),
    .bus          (bus),
    .overflow_o   (overflow),
    .fifo_level_o (fifo_level)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic sid_wr_t mk(input logic [2:0] c, input logic [4:0] r, input logic [7:0] d);
    sid_wr_t w;
    w.chip = c; w.regnum = r; w.data = d;
    return w;
  endfunction

  // clk_en strobe every CE_PERIOD cycles while enabled
  initial begin
    forever begin
      @(negedge sysclk);
      if (!ce_on) begin
        ce_cnt = 0; clk_en = 1'b0;
      end else if (ce_cnt == CE_PERIOD - 1) begin
        ce_cnt = 0; clk_en = 1'b1;
      end else begin
        ce_cnt++; clk_en = 1'b0;
      end
    end
  end

  // Bus monitor: compare each write at the falling select, check its width at release
  initial begin
    sid_wr_t    e;
    logic [1:0] exp_cs;
    logic [1:0] one;
    forever begin
      @(negedge sysclk);
      if (!n_reset) begin
        mon_prev = 2'b11;
        mon_low  = 0;
      end else begin
        if (mon_prev == 2'b11 && bus.sid_n_cs != 2'b11) begin
          mon_low = 1;
          if (sb.size() == 0) begin
            check("unexpected_write_cs", 32'(bus.sid_n_cs), 32'h3);
          end else begin
            e = sb.pop_front();
            one = 2'b01;
            exp_cs = ~(one << e.chip);
            check("write_n_cs", 32'(bus.sid_n_cs), 32'(exp_cs));
            check("write_addr", 32'(bus.sid_addr), 32'(e.regnum));
            check("write_data", 32'(bus.sid_data), 32'(e.data));
          end
        end else if (bus.sid_n_cs != 2'b11) begin
          mon_low++;
        end else if (mon_prev != 2'b11) begin
          check("n_cs_low_width", 32'(mon_low), 32'(CE_PERIOD));
        end
        mon_prev = bus.sid_n_cs;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    @(negedge sysclk);
    bus.s_tdata  = b;
    bus.s_tvalid = 1'b1;
    #1;
    while (!bus.s_tready && w < 2000) begin
      @(negedge sysclk); #1; w++;
    end
    if (!bus.s_tready) fail_now("send_byte_ready");
    @(negedge sysclk);
    bus.s_tvalid = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] d);
    send_byte(a);
    send_byte(d);
  endtask

  task automatic wait_drain(input string name);
    int w;
    w = 0;
    while ((sb.size() != 0 || bus.sid_n_cs != 2'b11 || fifo_level != 3'd0) && w < 3000) begin
      @(negedge sysclk); w++;
    end
    if (w >= 3000) fail_now(name);
    repeat (3) @(negedge sysclk);
  endtask

  initial begin
    int w;
    bus.s_tdata  = 8'h00;
    bus.s_tvalid = 1'b0;
    #2 n_reset = 1'b0;
    repeat (3) @(negedge sysclk);
    n_reset = 1'b1;
    #1;
    check("rst_n_cs",     32'(bus.sid_n_cs), 32'h3);
    check("rst_addr",     32'(bus.sid_addr), 32'h0);
    check("rst_data",     32'(bus.sid_data), 32'h0);
    check("rst_overflow", 32'(overflow),     32'h0);
    check("rst_level",    32'(fifo_level),   32'h0);
    check("rst_tready",   32'(bus.s_tready), 32'h1);

    ce_on = 1'b1;

    // chip 1, reg 0x18
    send_pair(8'h38, 8'h0F);
    sb.push_back(mk(3'd1, 5'h18, 8'h0F));
    wait_drain("drain_basic");

    // out-of-range chip byte is discarded
    send_byte(8'h60);
    send_pair(8'h05, 8'hAA);
    sb.push_back(mk(3'd0, 5'h05, 8'hAA));
    wait_drain("drain_resync");

    // pending address times out
    send_byte(8'h01);
    repeat (110) @(negedge sysclk);
    send_pair(8'h02, 8'h33);
    sb.push_back(mk(3'd0, 5'h02, 8'h33));
    wait_drain("drain_timeout");

    // fill the FIFO with clk_en stopped
    ce_on = 1'b0;
    send_pair(8'h03, 8'h11); sb.push_back(mk(3'd0, 5'h03, 8'h11));
    send_pair(8'h24, 8'h22); sb.push_back(mk(3'd1, 5'h04, 8'h22));
    send_pair(8'h1F, 8'h33); sb.push_back(mk(3'd0, 5'h1F, 8'h33));
    send_pair(8'h3F, 8'h44); sb.push_back(mk(3'd1, 5'h1F, 8'h44));
    check("full_level", 32'(fifo_level), 32'h4);
    send_byte(8'h01);
    @(negedge sysclk);
    bus.s_tdata  = 8'h55;
    bus.s_tvalid = 1'b1;
    #1;
    check("full_tready", 32'(bus.s_tready), 32'h0);
    check("full_level_hold", 32'(fifo_level), 32'h4);
    @(negedge sysclk);
    bus.s_tvalid = 1'b0;
    #1;
    check("overflow_set", 32'(overflow), 32'h1);
    ce_on = 1'b1;
    wait_drain("drain_fifo");
    check("fifo_empty_after", 32'(fifo_level), 32'h0);

    // reset while a write is in flight with three more queued
    ce_on = 1'b0;
    send_pair(8'h21, 8'h01); sb.push_back(mk(3'd1, 5'h01, 8'h01));
    send_pair(8'h02, 8'h02); sb.push_back(mk(3'd0, 5'h02, 8'h02));
    send_pair(8'h23, 8'h03); sb.push_back(mk(3'd1, 5'h03, 8'h03));
    send_pair(8'h04, 8'h04); sb.push_back(mk(3'd0, 5'h04, 8'h04));
    ce_on = 1'b1;
    w = 0;
    while (bus.sid_n_cs == 2'b11 && w < 200) begin
      @(negedge sysclk); w++;
    end
    if (bus.sid_n_cs == 2'b11) fail_now("wait_cs_low");
    repeat (10) @(negedge sysclk);
    check("pre_rst_level", 32'(fifo_level), 32'h3);
    #3 n_reset = 1'b0;
    #1;
    check("async_rst_n_cs",  32'(bus.sid_n_cs), 32'h3);
    check("async_rst_level", 32'(fifo_level),   32'h0);
    sb.delete();
    repeat (3) @(negedge sysclk);
    n_reset = 1'b1;
    #1;
    check("post_rst_overflow", 32'(overflow), 32'h0);
    repeat (300) @(negedge sysclk);
    check("post_rst_idle_cs", 32'(bus.sid_n_cs), 32'h3);
    check("post_rst_level",   32'(fifo_level),   32'h0);
    send_pair(8'h22, 8'h5A);
    sb.push_back(mk(3'd1, 5'h02, 8'h5A));
    wait_drain("drain_post_rst");

    repeat (5) @(negedge sysclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sid_write_router.md
# sid_write_router

Multi-chip successor to the single-SID byte-stream register writer. Parses an AXI-Stream-style byte stream of (address, data) pairs, buffers completed register writes in a FIFO, and issues them to one of `N_SID` mos6581 instances. Each write is paced to the 1 MHz `clk_en` strobe. Sits between the UART receiver (or memory player) and the SID bank in the top level.

## Interface
- `N_SID`, 2: number of SID chips, 1..8.
- `FIFO_DEPTH`, 16: write FIFO entries; power of 2, ≥2.
- `TIMEOUT`, 50000: sysclk cycles allowed in DATA state before resync; ≥1.
- `sysclk` in 1: clock.
- `n_reset` in 1: reset, asynchronous, active-low.
- `clk_en` in 1: 1-cycle SID bus strobe, at most one per 2 sysclk cycles.
- `s_tdata` in 8: stream byte.
- `s_tvalid` in 1: byte valid.
- `s_tready` out 1: byte accepted when `s_tvalid && s_tready`.
- `sid_addr` out 5: register address, shared by all chips.
- `sid_data` out 8: register data, shared.
- `sid_n_cs` out N_SID: per-chip active-low select.
- `overflow` out 1: sticky; source presented a byte while `s_tready` was low.
- `fifo_level` out $clog2(FIFO_DEPTH+1): current FIFO occupancy.

## Operation
- Address byte format: [4:0] register, [7:5] chip index.
- Parser FSM, reset state ADDR:
  - ADDR: an accepted byte with chip < N_SID latches chip and register, then → DATA. Chip ≥ N_SID: byte is consumed and discarded, stay in ADDR. This is the resync mechanism.
  - DATA: an accepted byte pushes {chip, reg, byte} into the FIFO, then → ADDR. A timeout counter increments every cycle no byte is accepted. When the count reaches TIMEOUT-1, the latched address is discarded, → ADDR, and the counter clears. The counter also clears on entry to DATA.
- `s_tready` = !(state==DATA && fifo full). It is always 1 in ADDR.
  - Full is evaluated before the same-cycle pop, so a pop and push never coincide on a full FIFO.
- Issuer FSM, reset state IDLE:
  - IDLE: on `clk_en` with FIFO non-empty, pop the head. Register `sid_addr`/`sid_data`; drive `sid_n_cs[chip]`=0 from the next cycle. → STROBE.
  - STROBE: hold all bus outputs. On the next `clk_en`, drive all `sid_n_cs` to 1 from the next cycle. → IDLE.
- Only one `sid_n_cs` bit is ever low at a time.
- `sid_addr`/`sid_data` keep their last values while idle.
- `overflow` is set on any cycle with `s_tvalid && !s_tready`. It is cleared only by reset.
- Reset values: `sid_n_cs` all 1, `sid_addr` 0, `sid_data` 0, `overflow` 0, `fifo_level` 0, `s_tready` 1, FIFO empty, both FSMs in their reset states.
- Reset mid-operation: an in-flight write is abandoned and `n_cs` is released immediately. A pending address is lost.

## Timing
- Byte accept to FIFO entry: 1 cycle; `fifo_level` updates the cycle after the push.
- FIFO entry to `n_cs` low: waits for the first `clk_en` at which the issuer is IDLE, plus 1 cycle.
- `n_cs` low width: exactly one `clk_en` period. It spans one complete `clk_en` strobe inside the low window.
- Throughput: at most one write per two `clk_en` periods.
- Push and pop in the same cycle on a non-empty, non-full FIFO: level is unchanged.
- Pop on the last entry with a simultaneous push: the new entry is retained.
- All outputs are registered except `s_tready`, which is combinational from state and full.

## Structure
- Package `sid_pkg`:
  - `sid_wr_t` struct {chip [2:0], reg [4:0], data [7:0]}.
  - Parser enum {ADDR, DATA}.
  - Issuer enum {IDLE, STROBE}.
  - Constants `SID_REG_BITS`=5 and `SID_CHIP_BITS`=3.
- Sub-module `sync_fifo`: parametrised width/depth, single clock, async active-low reset. Signals: push, pop, full, empty, level, registered head. Intended for reuse elsewhere.

## Test plan
- N_SID=2, `clk_en` every 50 cycles. Send 0x38 0x0F, which is chip 1, reg 0x18.
  - Required: one write with addr 0x18, data 0x0F.
  - `sid_n_cs`=2'b01 for exactly 50 cycles; chip 0 never selected.
- Send 0x60 (chip 3 ≥ N_SID), then 0x05 0xAA.
  - Required: 0x60 discarded, 0x05 treated as an address, single write reg 5 = 0xAA to chip 0.
- TIMEOUT=100: send 0x01 and stall 100 cycles, then send 0x02 0x33.
  - Required: no write for 0x01; write reg 2 = 0x33.
- FIFO_DEPTH=4, `clk_en` held 0: send 5 pairs.
  - Required: `fifo_level`=4 and `s_tready` low on the 5th data byte.
  - With the source ignoring backpressure, `overflow`=1.
  - After enabling `clk_en`, 4 writes are issued in order.
- Assert `n_reset` while `n_cs` is low with 3 entries queued.
  - Required: `sid_n_cs` all 1 asynchronously, `fifo_level`=0, and no write after reset release until a new pair is received.
